// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared definitions for the pipelined ALU.
//   - opcode encodings (fixed 4-bit encoding)
//   - flag bit positions within the 4-bit flags bus
//   - FSM state encoding for the top-level control
package alu_pipe_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_NOR  = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_XNOR = 4'h9;
  localparam logic [3:0] OP_EQ   = 4'hA;
  localparam logic [3:0] OP_GT   = 4'hB;
  localparam logic [3:0] OP_LT   = 4'hC;
  localparam logic [3:0] OP_SHR  = 4'hD;
  localparam logic [3:0] OP_SHL  = 4'hE;
  localparam logic [3:0] OP_ASR  = 4'hF;

  localparam int unsigned FLG_CARRY = 0;
  localparam int unsigned FLG_ZERO  = 1;
  localparam int unsigned FLG_OVF   = 2;
  localparam int unsigned FLG_DZ    = 3;
  localparam int unsigned NUM_FLAGS = 4;

  typedef enum logic [0:0] {
    StIdle,
    StDiv
  } state_e;

endpackage

// File: rtl/alu_pipe_seq_divider.sv
// alu_pipe_seq_divider: iterative unsigned restoring divider, one quotient bit per cycle.
//   clk, rst   : clock and asynchronous active-high reset (reset aborts a division)
//   start      : load dividend/divisor and begin; ignored while busy
//   dividend   : W-bit dividend
//   divisor    : W-bit divisor (caller guarantees non-zero)
//   busy       : iterations in progress
//   done       : high during the cycle whose closing edge performs the last iteration
//   quotient   : valid while done is high
//   remainder  : valid while done is high
// quotient/remainder are the combinational result of the current iteration so the
// consumer can capture the final answer on the same edge the last iteration retires.
module alu_pipe_seq_divider #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int unsigned CntW = $clog2(W + 1);

  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    dvs_q, dvs_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;

  logic [W:0]      shifted;
  logic [W:0]      trial;
  logic            take;
  logic [W-1:0]    rem_step;
  logic [W-1:0]    quo_step;

  // One restoring step: shift the next dividend bit into the partial remainder and
  // subtract the divisor if it fits.
  always_comb begin
    shifted  = {rem_q, quo_q[W-1]};
    trial    = shifted - {1'b0, dvs_q};
    take     = ~trial[W];
    rem_step = take ? trial[W-1:0] : shifted[W-1:0];
    quo_step = {quo_q[W-2:0], take};
  end

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (busy_q) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        busy_d = 1'b0;
      end
    end else if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
      cnt_d  = CntW'(W);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == CntW'(1));
  assign quotient  = quo_step;
  assign remainder = rem_step;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes and a multi-cycle divider.
//   clk, rst    : clock and asynchronous active-high reset
//   a, b        : operands (DATA_WIDTH bits)
//   alu_fun     : opcode (see alu_pipe_pkg)
//   in_valid    : operation offered
//   in_ready    : operation can be accepted this cycle
//   alu_out     : result low word (quotient for divide)
//   alu_out_hi  : result high word (product high half / remainder, else 0)
//   flags       : {div_zero, overflow, zero, carry}
//   out_valid   : result register holds an undelivered result
//   out_ready   : consumer takes the result this cycle
// Non-divide ops retire on the accept edge. A divide with non-zero divisor parks the
// FSM in StDiv for DATA_WIDTH cycles and loads the result on the final iteration.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FUN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [FUN_WIDTH-1:0]  alu_fun,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic [DATA_WIDTH-1:0] alu_out_hi,
  output logic [NUM_FLAGS-1:0]  flags,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int unsigned W = DATA_WIDTH;

  state_e state_q, state_d;

  logic [W-1:0]         res_lo_q, res_lo_d;
  logic [W-1:0]         res_hi_q, res_hi_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic                 out_valid_q, out_valid_d;

  logic                 accept;
  logic                 div_start;
  logic                 div_busy;
  logic                 div_done;
  logic [W-1:0]         div_quo;
  logic [W-1:0]         div_rem;

  logic [W:0]           sum;
  logic [W:0]           diff;
  logic [2*W-1:0]       prod;
  logic [W-1:0]         comb_lo;
  logic [W-1:0]         comb_hi;
  logic [NUM_FLAGS-1:0] comb_flags;

  assign in_ready  = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign div_start = accept && (alu_fun == OP_DIV) && (b != '0);

  alu_pipe_seq_divider #(
    .W (W)
  ) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (a),
    .divisor   (b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Single-cycle operation results and flags.
  always_comb begin
    sum        = {1'b0, a} + {1'b0, b};
    diff       = {1'b0, a} - {1'b0, b};
    prod       = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    comb_lo    = '0;
    comb_hi    = '0;
    comb_flags = '0;
    case (alu_fun)
      OP_ADD: begin
        comb_lo               = sum[W-1:0];
        comb_flags[FLG_CARRY] = sum[W];
        comb_flags[FLG_OVF]   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        comb_lo               = diff[W-1:0];
        comb_flags[FLG_CARRY] = diff[W];  // borrow
        comb_flags[FLG_OVF]   = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      OP_MUL: begin
        comb_lo = prod[W-1:0];
        comb_hi = prod[2*W-1:W];
      end
      OP_DIV: begin
        // Only reaches the output register when b == 0; other divides go to the FSM.
        comb_lo            = '1;
        comb_hi            = a;
        comb_flags[FLG_DZ] = 1'b1;
      end
      OP_AND:  comb_lo = a & b;
      OP_OR:   comb_lo = a | b;
      OP_NAND: comb_lo = ~(a & b);
      OP_NOR:  comb_lo = ~(a | b);
      OP_XOR:  comb_lo = a ^ b;
      OP_XNOR: comb_lo = ~(a ^ b);
      OP_EQ:   comb_lo = (a == b) ? W'(1) : '0;
      OP_GT:   comb_lo = (a > b)  ? W'(2) : '0;
      OP_LT:   comb_lo = (a < b)  ? W'(3) : '0;
      OP_SHR: begin
        comb_lo               = {1'b0, a[W-1:1]};
        comb_flags[FLG_CARRY] = a[0];
      end
      OP_SHL: begin
        comb_lo               = {a[W-2:0], 1'b0};
        comb_flags[FLG_CARRY] = a[W-1];
      end
      OP_ASR: begin
        comb_lo               = {a[W-1], a[W-1:1]};
        comb_flags[FLG_CARRY] = a[0];
      end
      default: ;
    endcase
    comb_flags[FLG_ZERO] = ~|{comb_hi, comb_lo};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (div_start) state_d = StDiv;
      StDiv:  if (div_done)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output register: hold under backpressure, drain on out_ready, load on retire.
  always_comb begin
    res_lo_d    = res_lo_q;
    res_hi_d    = res_hi_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q && !out_ready;
    if (div_done && (state_q == StDiv)) begin
      res_lo_d            = div_quo;
      res_hi_d            = div_rem;
      flags_d             = '0;
      flags_d[FLG_ZERO]   = ~|{div_rem, div_quo};
      out_valid_d         = 1'b1;
    end else if (accept && !div_start) begin
      res_lo_d    = comb_lo;
      res_hi_d    = comb_hi;
      flags_d     = comb_flags;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_lo_q    <= res_lo_d;
      res_hi_q    <= res_hi_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign alu_out    = res_lo_q;
  assign alu_out_hi = res_hi_q;
  assign flags      = flags_q;
  assign out_valid  = out_valid_q;

`ifndef SYNTHESIS
  // The slot was free or draining when the divide was accepted, so completion must
  // never find an undelivered result.
  assert property (@(posedge clk) disable iff (rst) div_done |-> !out_valid_q);
  assert property (@(posedge clk) disable iff (rst) (state_q == StDiv) == div_busy);
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed-vector bench for alu_pipe (DATA_WIDTH = 8).
// Stimulus pushes the hand-computed expected result when an op is accepted; a
// monitor pops and compares each result as it is handed to the consumer.
module tb_alu_pipe;

  localparam logic [3:0] F_ADD  = 4'h0;
  localparam logic [3:0] F_SUB  = 4'h1;
  localparam logic [3:0] F_MUL  = 4'h2;
  localparam logic [3:0] F_DIV  = 4'h3;
  localparam logic [3:0] F_AND  = 4'h4;
  localparam logic [3:0] F_OR   = 4'h5;
  localparam logic [3:0] F_NAND = 4'h6;
  localparam logic [3:0] F_NOR  = 4'h7;
  localparam logic [3:0] F_XOR  = 4'h8;
  localparam logic [3:0] F_XNOR = 4'h9;
  localparam logic [3:0] F_EQ   = 4'hA;
  localparam logic [3:0] F_GT   = 4'hB;
  localparam logic [3:0] F_LT   = 4'hC;
  localparam logic [3:0] F_SHR  = 4'hD;
  localparam logic [3:0] F_SHL  = 4'hE;
  localparam logic [3:0] F_ASR  = 4'hF;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic [3:0] alu_fun;
  logic       in_valid, in_ready;
  logic [7:0] alu_out, alu_out_hi;
  logic [3:0] flags;
  logic       out_valid, out_ready;

  typedef struct packed {
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] fl;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  alu_pipe #(
    .DATA_WIDTH (8),
    .FUN_WIDTH  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .alu_fun    (alu_fun),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_out    (alu_out),
    .alu_out_hi (alu_out_hi),
    .flags      (flags),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Offer one op and wait (bounded) for acceptance; returns 1ns after the accept edge.
  task automatic issue(input logic [3:0] f, input logic [7:0] aa, input logic [7:0] bb,
                       input logic [7:0] elo, input logic [7:0] ehi, input logic [3:0] efl,
                       input bit expect_result);
    int n;
    exp_t e;
    n        = 0;
    alu_fun  = f;
    a        = aa;
    b        = bb;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: op 0x%0h never accepted", f);
    end else if (expect_result) begin
      e.lo = elo;
      e.hi = ehi;
      e.fl = efl;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor: compare every result the consumer takes.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got lo 0x%0h hi 0x%0h with none pending",
                 alu_out, alu_out_hi);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_lo", 32'(alu_out), 32'(e.lo));
        check("result_hi", 32'(alu_out_hi), 32'(e.hi));
        check("result_flags", 32'(flags), 32'(e.fl));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    alu_fun   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_alu_out", 32'(alu_out), 32'h0);
    check("reset_alu_out_hi", 32'(alu_out_hi), 32'h0);
    check("reset_flags", 32'(flags), 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;

    // Arithmetic. flags = {div_zero, overflow, zero, carry}
    issue(F_ADD, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b0100, 1);
    check("add_latency_valid", 32'(out_valid), 32'h1);
    check("add_ovf_out", 32'(alu_out), 32'h80);
    issue(F_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b0011, 1);
    issue(F_SUB, 8'h05, 8'h07, 8'hFE, 8'h00, 4'b0001, 1);
    issue(F_SUB, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b0100, 1);
    issue(F_MUL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0000, 1);
    issue(F_MUL, 8'h00, 8'h12, 8'h00, 8'h00, 4'b0010, 1);
    // Logic, compare, shift.
    issue(F_AND,  8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000, 1);
    issue(F_OR,   8'hF0, 8'h3C, 8'hFC, 8'h00, 4'b0000, 1);
    issue(F_NAND, 8'hF0, 8'h3C, 8'hCF, 8'h00, 4'b0000, 1);
    issue(F_NOR,  8'hF0, 8'h3C, 8'h03, 8'h00, 4'b0000, 1);
    issue(F_XOR,  8'hF0, 8'h3C, 8'hCC, 8'h00, 4'b0000, 1);
    issue(F_XNOR, 8'hF0, 8'h3C, 8'h33, 8'h00, 4'b0000, 1);
    issue(F_EQ,   8'h05, 8'h05, 8'h01, 8'h00, 4'b0000, 1);
    issue(F_EQ,   8'h05, 8'h06, 8'h00, 8'h00, 4'b0010, 1);
    issue(F_GT,   8'h80, 8'h7F, 8'h02, 8'h00, 4'b0000, 1);
    issue(F_LT,   8'h01, 8'hFF, 8'h03, 8'h00, 4'b0000, 1);
    issue(F_LT,   8'hFF, 8'h01, 8'h00, 8'h00, 4'b0010, 1);
    issue(F_SHR,  8'h81, 8'h00, 8'h40, 8'h00, 4'b0001, 1);
    issue(F_SHL,  8'h81, 8'h00, 8'h02, 8'h00, 4'b0001, 1);
    issue(F_ASR,  8'h81, 8'h00, 8'hC0, 8'h00, 4'b0001, 1);
    issue(F_ASR,  8'h01, 8'h00, 8'h00, 8'h00, 4'b0011, 1);
    // Divide by zero is a single-cycle op.
    issue(F_DIV,  8'h35, 8'h00, 8'hFF, 8'h35, 4'b1000, 1);
    check("dz_latency_valid", 32'(out_valid), 32'h1);
    check("dz_flags_now", 32'(flags), 32'h8);

    // Divide latency: 200 / 7 = 28 rem 4, result visible 9 cycles after accept.
    // An ADD is held on the inputs throughout and must only be taken once idle.
    issue(F_DIV, 8'd200, 8'd7, 8'd28, 8'd4, 4'b0000, 1);
    alu_fun  = F_ADD;
    a        = 8'h01;
    b        = 8'h02;
    in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("div_in_ready_c%0d", k), 32'(in_ready), 32'h0);
      check($sformatf("div_out_valid_c%0d", k), 32'(out_valid), 32'h0);
      @(posedge clk);
      #1;
    end
    check("div_out_valid_c9", 32'(out_valid), 32'h1);
    check("div_quotient_c9", 32'(alu_out), 32'd28);
    check("div_remainder_c9", 32'(alu_out_hi), 32'd4);
    exp_q.push_back('{lo: 8'h03, hi: 8'h00, fl: 4'b0000});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("post_div_add_out", 32'(alu_out), 32'h3);
    issue(F_DIV, 8'd0, 8'd5, 8'd0, 8'd0, 4'b0010, 1);
    repeat (9) @(posedge clk);
    #1;
    issue(F_DIV, 8'd255, 8'd1, 8'd255, 8'd0, 4'b0000, 1);
    repeat (9) @(posedge clk);
    #1;

    // Reset in the middle of a divide aborts it.
    issue(F_ADD, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b0100, 1);
    issue(F_DIV, 8'd200, 8'd7, 8'd0, 8'd0, 4'b0000, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_alu_out", 32'(alu_out), 32'h0);
    check("midrst_flags", 32'(flags), 32'h0);
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'h1);
    check("midrst_alu_out_hi", 32'(alu_out_hi), 32'h0);
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_late_result", 32'(out_valid), 32'h0);
    check("midrst_still_ready", 32'(in_ready), 32'h1);

    // Backpressure: XOR result held for 5 cycles while an AND is offered.
    out_ready = 1'b0;
    issue(F_XOR, 8'hA5, 8'h0F, 8'hAA, 8'h00, 4'b0000, 1);
    alu_fun  = F_AND;
    a        = 8'hA5;
    b        = 8'h0F;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_in_ready_%0d", k), 32'(in_ready), 32'h0);
      check($sformatf("bp_alu_out_%0d", k), 32'(alu_out), 32'hAA);
      check($sformatf("bp_out_valid_%0d", k), 32'(out_valid), 32'h1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    issue(F_AND, 8'hA5, 8'h0F, 8'h05, 8'h00, 4'b0000, 1);
    check("b2b_and_out", 32'(alu_out), 32'h05);
    issue(F_OR, 8'hA5, 8'h0F, 8'hAF, 8'h00, 4'b0000, 1);
    check("b2b_or_out", 32'(alu_out), 32'hAF);
    check("b2b_or_valid", 32'(out_valid), 32'h1);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
